// File: rtl/seg_scan_scheduler.sv
// Round-robin 7-segment scan over four anodes with a blanking gap before every slot.
// Each slot snapshots its digit code and decimal point so a digit never changes mid-slot.
module seg_scan_scheduler #(
  parameter int SLOT_CYC  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       basys_clock,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        started_q, started_d;
  logic [3:0]  snap_code_q, snap_code_d;
  logic        snap_dp_q, snap_dp_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        tick_q, tick_d;

  logic [3:0]  digit_vec [4];
  logic [1:0]  nxt;
  logic        nxt_found;

  assign digit_vec[0] = digit0;
  assign digit_vec[1] = digit1;
  assign digit_vec[2] = digit2;
  assign digit_vec[3] = digit3;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      4'd10:   s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Search starts one past the current pointer so the current digit is considered last.
  always_comb begin
    logic [1:0] idx;
    nxt       = ptr_q;
    nxt_found = 1'b0;
    idx       = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!nxt_found && digit_en[idx]) begin
        nxt_found = 1'b1;
        nxt       = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    started_d   = started_q;
    snap_code_d = snap_code_q;
    snap_dp_d   = snap_dp_q;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    an_d        = 4'hF;
    tick_d      = 1'b0;
    case (state_q)
      IDLE: begin
        started_d = 1'b0;
        if (digit_en != 4'd0) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          if (nxt_found) begin
            state_d     = DRIVE;
            cnt_d       = cnt_q + CW'(1);
            ptr_d       = nxt;
            snap_code_d = digit_vec[nxt];
            snap_dp_d   = dp_in[nxt];
            started_d   = 1'b1;
            tick_d      = started_q && (nxt <= ptr_q);
            seg_d       = decode(digit_vec[nxt]);
            dp_d        = ~dp_in[nxt];
            an_d        = ~(4'b0001 << nxt);
          end else begin
            state_d   = IDLE;
            cnt_d     = '0;
            started_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        // cnt keeps counting through the whole slot, so the drive phase ends at SLOT_CYC-1.
        if (cnt_q == SLOT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          seg_d = decode(snap_code_q);
          dp_d  = ~snap_dp_q;
          an_d  = ~(4'b0001 << ptr_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
      started_q   <= 1'b0;
      snap_code_q <= 4'hF;
      snap_dp_q   <= 1'b0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= 4'hF;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      started_q   <= started_d;
      snap_code_q <= snap_code_d;
      snap_dp_q   <= snap_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
